// File: rtl/abr_prim_sec_anchor_reg.sv
// ----------------------------------------------------------------------------
// abr_prim_flop
//   Plain Width-bit register with synchronous active-low reset. It gets its own
//   module so every redundant copy ends up as a distinct instance that
//   synthesis keeps separate.
//   Ports:
//     clk_i  - clock
//     rst_b  - synchronous active-low reset (loads ResetValue)
//     d_i    - next value
//     q_o    - registered value
// ----------------------------------------------------------------------------
module abr_prim_flop #(
   parameter int unsigned      Width      = 1,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_b,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] r_q;

   always_ff @(posedge clk_i) begin
      if (!rst_b) begin
         r_q <= ResetValue;
      end else begin
         r_q <= d_i;
      end
   end

   assign q_o = r_q;

endmodule

// ----------------------------------------------------------------------------
// abr_prim_sec_anchor_reg
//   Multi-channel write-enabled security anchor register. Every channel is
//   stored as a true copy plus a complemented shadow copy; the pair is
//   compared every cycle. Any mismatch moves a sparse-encoded lock FSM into
//   LOCK, which forces q_o to ErrValue and raises alert_o until reset.
//   Ports:
//     clk_i    - clock
//     rst_b    - synchronous active-low reset
//     we_i     - per-channel write enable (ignored while locked)
//     d_i      - write data, channel c at [c*Width +: Width]
//     q_o      - channel values, or ErrValue on every channel while locked
//     alert_o  - lock indication, decoded from the state register
//     err_ch_o - sticky per-channel mismatch flags
// ----------------------------------------------------------------------------
module abr_prim_sec_anchor_reg #(
   parameter int unsigned      Width      = 8,
   parameter int unsigned      NumCh      = 2,
   parameter logic [Width-1:0] ResetValue = '0,
   parameter logic [Width-1:0] ErrValue   = '0
) (
   input  logic                   clk_i,
   input  logic                   rst_b,
   input  logic [NumCh-1:0]       we_i,
   input  logic [NumCh*Width-1:0] d_i,
   output logic [NumCh*Width-1:0] q_o,
   output logic                   alert_o,
   output logic [NumCh-1:0]       err_ch_o
);

   // Sparse encodings: Hamming distance 8 between the two legal states.
   typedef enum logic [7:0] {
      StRun  = 8'b1001_0110,
      StLock = 8'b0110_1001
   } state_e;

   logic [NumCh-1:0][Width-1:0] w_true_q;
   logic [NumCh-1:0][Width-1:0] w_shadow_q;
   logic [NumCh-1:0][Width-1:0] w_true_d;
   logic [NumCh-1:0][Width-1:0] w_shadow_d;
   logic [NumCh-1:0]            w_mis;
   logic [NumCh-1:0]            w_we;
   logic [7:0]                  w_state_q;
   logic [7:0]                  w_state_d;
   logic                        w_locked;
   logic [NumCh-1:0]            r_err_ch;

   // Anything other than exactly StRun counts as locked, so corrupted
   // encodings fail safe.
   assign w_locked = (w_state_q != StRun);
   assign w_we     = we_i & {NumCh{~w_locked}};

   for (genvar c = 0; c < NumCh; c++) begin : g_ch
      assign w_true_d[c]   = w_we[c] ? d_i[c*Width +: Width]  : w_true_q[c];
      assign w_shadow_d[c] = w_we[c] ? ~d_i[c*Width +: Width] : w_shadow_q[c];
      // Compare registered copies only; d_i never reaches the checker.
      assign w_mis[c]      = (w_true_q[c] != ~w_shadow_q[c]);

      abr_prim_flop #(
         .Width      (Width),
         .ResetValue (ResetValue)
      ) u_true (
         .clk_i (clk_i),
         .rst_b (rst_b),
         .d_i   (w_true_d[c]),
         .q_o   (w_true_q[c])
      );

      abr_prim_flop #(
         .Width      (Width),
         .ResetValue (~ResetValue)
      ) u_shadow (
         .clk_i (clk_i),
         .rst_b (rst_b),
         .d_i   (w_shadow_d[c]),
         .q_o   (w_shadow_q[c])
      );
   end

   // LOCK is absorbing; only reset (inside the flop) returns to StRun.
   assign w_state_d = (w_locked || (|w_mis)) ? StLock : StRun;

   abr_prim_flop #(
      .Width      (8),
      .ResetValue (StRun)
   ) u_state (
      .clk_i (clk_i),
      .rst_b (rst_b),
      .d_i   (w_state_d),
      .q_o   (w_state_q)
   );

   // Keeps accumulating in LOCK so channels that fail later are still flagged.
   always_ff @(posedge clk_i) begin
      if (!rst_b) begin
         r_err_ch <= '0;
      end else begin
         r_err_ch <= r_err_ch | w_mis;
      end
   end

   always_comb begin
      q_o = '0;
      for (int c = 0; c < NumCh; c++) begin
         q_o[c*Width +: Width] = w_locked ? ErrValue : w_true_q[c];
      end
   end

   assign alert_o  = w_locked;
   assign err_ch_o = r_err_ch;

   a_alert_known: assert property (@(posedge clk_i) disable iff (!rst_b)
      !$isunknown(alert_o));

   a_err_monotonic: assert property (@(posedge clk_i) disable iff (!rst_b)
      $past(rst_b) |-> ((err_ch_o & $past(err_ch_o)) == $past(err_ch_o)));

   a_lock_forces_q: assert property (@(posedge clk_i) disable iff (!rst_b)
      w_locked |-> (q_o == {NumCh{ErrValue}}));

endmodule

// File: tb/tb_abr_prim_sec_anchor_reg.sv
// ----------------------------------------------------------------------------
// tb_abr_prim_sec_anchor_reg
//   Directed bench for abr_prim_sec_anchor_reg (Width=8, NumCh=2, reset and
//   error values 0). Stimulus runs on the falling edge and queues the outputs
//   expected after the next rising edge; a monitor pops and compares shortly
//   after each rising edge. Shadow/state faults are injected with force.
// ----------------------------------------------------------------------------
module tb_abr_prim_sec_anchor_reg;

   typedef struct {
      logic [15:0] q;
      logic        alert;
      logic [1:0]  err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic [1:0]  we_i = 2'b00;
   logic [15:0] d_i = 16'h0000;
   logic [15:0] q_o;
   logic        alert_o;
   logic [1:0]  err_ch_o;

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   abr_prim_sec_anchor_reg #(
      .Width      (8),
      .NumCh      (2),
      .ResetValue (8'h00),
      .ErrValue   (8'h00)
   ) dut (
      .clk_i    (clk),
      .rst_b    (rst_b),
      .we_i     (we_i),
      .d_i      (d_i),
      .q_o      (q_o),
      .alert_o  (alert_o),
      .err_ch_o (err_ch_o)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the edge.
   task automatic step(input logic rst, input logic [1:0] we, input logic [15:0] d,
                       input logic [15:0] eq, input logic ea, input logic [1:0] ee);
      exp_t e;
      rst_b = rst;
      we_i  = we;
      d_i   = d;
      e.q = eq; e.alert = ea; e.err = ee;
      sb.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: outputs are valid every cycle, compare whenever one is queued.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("q_o", q_o, e.q);
         check("alert_o", {15'd0, alert_o}, {15'd0, e.alert});
         check("err_ch_o", {14'd0, err_ch_o}, {14'd0, e.err});
      end
   end

   initial begin
      @(negedge clk);
      // Reset, then idle.
      step(1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 2'b00);
      for (int i = 0; i < 10; i++) step(1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 2'b00);

      // Single-channel write, then both channels.
      step(1'b1, 2'b01, 16'hFFA5, 16'h00A5, 1'b0, 2'b00);
      step(1'b1, 2'b11, 16'h3C5A, 16'h3C5A, 1'b0, 2'b00);
      // Upper channel only; lower channel must hold.
      step(1'b1, 2'b10, 16'h3C77, 16'h3C5A, 1'b0, 2'b00);

      // Flip one bit of channel 1's shadow (3C stored -> shadow C3).
      force dut.g_ch[1].u_shadow.r_q = 8'hC2;
      step(1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 2'b10);
      release dut.g_ch[1].u_shadow.r_q;
      step(1'b1, 2'b11, 16'hFFFF, 16'h0000, 1'b1, 2'b10);
      step(1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 2'b10);

      // Reset out of LOCK.
      step(1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 2'b00);

      // Both shadows corrupted in the same cycle as a channel-0 write.
      force dut.g_ch[0].u_shadow.r_q = 8'hFE;
      force dut.g_ch[1].u_shadow.r_q = 8'hFE;
      step(1'b1, 2'b01, 16'h00A5, 16'h0000, 1'b1, 2'b11);
      release dut.g_ch[0].u_shadow.r_q;
      release dut.g_ch[1].u_shadow.r_q;
      step(1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 2'b00);

      // Illegal state encoding: locks immediately, settles to LOCK.
      force dut.u_state.r_q = 8'h00;
      #1;
      check("alert_illegal_now", {15'd0, alert_o}, 16'h0001);
      check("q_illegal_now", q_o, 16'h0000);
      @(negedge clk);
      step(1'b1, 2'b11, 16'h5555, 16'h0000, 1'b1, 2'b00);
      release dut.u_state.r_q;
      step(1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 2'b00);
      check("state_lock", {8'd0, dut.u_state.r_q}, 16'h0069);
      step(1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 2'b00);
      check("state_run", {8'd0, dut.u_state.r_q}, 16'h0096);

      // Write coinciding with reset: reset wins. Writes resume afterwards.
      step(1'b1, 2'b11, 16'h0F0F, 16'h0F0F, 1'b0, 2'b00);
      step(1'b0, 2'b11, 16'h1234, 16'h0000, 1'b0, 2'b00);
      step(1'b1, 2'b11, 16'h1234, 16'h1234, 1'b0, 2'b00);
      step(1'b1, 2'b00, 16'hABCD, 16'h1234, 1'b0, 2'b00);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/abr_prim_sec_anchor_reg.md
Name: abr_prim_sec_anchor_reg

Overview:
- Multi-channel, write-enabled security anchor register for the abr_prim library.
- Each channel is stored twice: a true copy and a complemented shadow copy, each in its own abr_prim_flop instance so synthesis cannot merge them.
- The two copies are checked against each other every cycle. A sparse-encoded lock FSM latches any mismatch and forces all outputs to a safe value until reset.
- Used for keys, mode bits and FSM-adjacent state that must survive single-flop faults detectably.

Parameters:
- Width, 8, bits per channel.
- NumCh, 2, number of independent channels.
- ResetValue, 0 (Width bits), reset value of every channel's true copy.
- ErrValue, 0 (Width bits), value driven on every channel of q_o while locked.

Ports:
- clk_i  input  1  clock.
- rst_b  input  1  synchronous active-low reset.
- we_i  input  NumCh  per-channel write enable.
- d_i  input  NumCh*Width  write data; channel c occupies bits [c*Width +: Width].
- q_o  output  NumCh*Width  registered channel values, or ErrValue when locked.
- alert_o  output  1  lock indication, driven from the FSM state register.
- err_ch_o  output  NumCh  sticky per-channel mismatch flags.

Behaviour:
- Interface (decided): one clock, clk_i; reset rst_b is synchronous and active-low. Every flop updates only on the rising edge of clk_i, including reset.
- Storage per channel c:
  - u_true[c] holds the true value.
  - u_shadow[c] holds its bitwise complement.
  - Both are separate abr_prim_flop instances, named exactly u_true[c] and u_shadow[c].
- Reset (rst_b=0 at an edge):
  - true copy = ResetValue; shadow = ~ResetValue.
  - state = RUN; err_ch_o = 0.
  - So q_o = {NumCh{ResetValue}} and alert_o = 0 from the next cycle.
- Write, RUN state: we_i[c]=1 at edge k loads true = d_i[c] and shadow = ~d_i[c]. q_o[c] shows the new value after edge k (one-cycle latency). Channels with we_i[c]=0 hold.
- Mismatch detect: combinational mis[c] = (true[c] != ~shadow[c]), computed on registered values only, never on d_i.
- Lock FSM:
  - States RUN = 8'b1001_0110 and LOCK = 8'b0110_1001, held in one 8-bit abr_prim_flop.
  - RUN -> LOCK at the next edge if any mis[c]=1.
  - LOCK -> LOCK until reset; there is no software clear.
  - Any state value other than RUN or LOCK is treated as LOCK (alert_o=1, outputs forced) and the next state is LOCK.
- err_ch_o[c] sets at the edge after mis[c]=1 and stays set until reset. It keeps updating in LOCK, so later mismatching channels also flag.
- LOCK effects:
  - Every channel of q_o = ErrValue, combinationally gated from the state.
  - alert_o = 1.
  - we_i is ignored; stored copies hold.
- Simultaneous events:
  - A write in the same cycle as a mismatch still loads the channel, but lock wins at that edge, so q_o shows ErrValue afterwards.
  - Two channels mismatching in the same cycle both set err_ch_o in the same edge.
- Reset while in LOCK: return to RUN with reset values at that edge. Reset takes priority over writes and lock.
- Timing: mismatch visible after edge k -> alert_o=1 and q_o forced after edge k+1, i.e. one cycle of detection latency.
- Assertions:
  - alert_o is never X after reset.
  - err_ch_o is monotonic outside reset.
  - LOCK implies q_o == {NumCh{ErrValue}}.

Test Plan:
- Reset then idle, Width=8, NumCh=2, ResetValue=8'h00: q_o=16'h0000, alert_o=0, err_ch_o=2'b00 for 10 cycles.
- we_i=2'b01, d_i=16'hxxA5 -> next cycle q_o[7:0]=8'hA5 and q_o[15:8] unchanged at 8'h00. Then we_i=2'b11, d_i=16'h3C5A -> q_o=16'h3C5A after one cycle.
- Force a bit in u_shadow[1] for one cycle after storing 8'h3C -> alert_o=1 and err_ch_o=2'b10 one cycle later. q_o=16'h0000 (ErrValue); a write with we_i=2'b11, d_i=16'hFFFF leaves q_o=16'h0000.
- Force both shadows in the same cycle while we_i=2'b01 -> err_ch_o=2'b11, alert_o=1 next cycle, q_o forced.
- Force the state flop to 8'h00 -> alert_o=1 immediately and the state becomes LOCK at the next edge. Then hold rst_b=0 for one edge -> state RUN, q_o=16'h0000, alert_o=0, err_ch_o=0.
- Write at the same edge rst_b=0 with d_i=16'h1234 -> reset wins, q_o=16'h0000.
